operand_fifo16: RTL and testbench



---
 rtl/operand_fifo16_if.sv | 29 ++
 rtl/operand_fifo16.sv | 79 +++++++
 tb/tb_operand_fifo16.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/operand_fifo16_if.sv
// Handshake bundle between the operand producer, operand_fifo16 and the OR stage.
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface operand_fifo16_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [CW-1:0]    count;

   modport slave (
      input  flush, in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_a, out_b, count
   );

   modport master (
      output flush, in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_a, out_b, count
   );
endinterface

// File: rtl/operand_fifo16.sv
// Four-entry operand-pair FIFO feeding the bitwise OR stage.
// Ready/valid come only from the registered count, so there is no comb path from in_valid/out_ready.
module operand_fifo16 #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   operand_fifo16_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [2*WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = bus.in_valid & in_ready;
   assign pop       = out_valid & bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_a     = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
   assign bus.out_b     = mem_q[rd_ptr_q][WIDTH-1:0];
   assign bus.count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (bus.flush) begin
         // Storage is left as-is; only the bookkeeping is cleared.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {bus.in_a, bus.in_b};
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: tb/tb_operand_fifo16.sv
// Scoreboard bench for operand_fifo16: accepted pushes enqueue expected pairs,
// an independent monitor pops and compares whenever the DUT pops.
module tb_operand_fifo16;
   logic clk;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [31:0] exp_q [$];

   operand_fifo16_if #(.DEPTH(4), .WIDTH(16)) bus ();

   operand_fifo16 #(.DEPTH(4), .WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Record an accepted push at mid-cycle, then advance to just after the next edge.
   task automatic clk_cyc();
      @(negedge clk);
      if (bus.flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_a, bus.in_b});
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic rdy);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = rdy;
   endtask

   // Monitor: compares the head against the scoreboard on every DUT pop.
   always @(negedge clk) begin
      if (reset_n && !bus.flush && bus.out_valid && bus.out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h%0h expected no data", bus.out_a, bus.out_b);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if ({bus.out_a, bus.out_b} !== e) begin
               n_fail++;
               $display("FAIL pop_data: got 0x%08h expected 0x%08h at %0t", {bus.out_a, bus.out_b}, e, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n   = 1'b0;
      bus.flush = 1'b0;
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
         drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      end
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_out_a", 32'(bus.out_a), 32'h0);
      chk("rst_out_b", 32'(bus.out_b), 32'h0);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      reset_n = 1'b1;

      // Single pass
      drive(1'b1, 16'h00F0, 16'h0F00, 1'b0);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_a", 32'(bus.out_a), 32'h00F0);
      chk("single_b", 32'(bus.out_b), 32'h0F00);
      chk("single_count", 32'(bus.count), 32'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("single_drain_count", 32'(bus.count), 32'd0);
      chk("single_drain_valid", 32'(bus.out_valid), 32'd0);

      // Fill to full, refused fifth push
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'(i), 16'(i << 12), 1'b0);
         clk_cyc();
      end
      chk("full_count", 32'(bus.count), 32'd4);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 16'h0005, 16'h5000, 1'b0);
      clk_cyc();
      chk("full_refuse_count", 32'(bus.count), 32'd4);

      // Full with simultaneous pop: push refused, pop happens
      drive(1'b1, 16'h0005, 16'h5000, 1'b1);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      chk("full_pop_count", 32'(bus.count), 32'd3);
      chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (3) clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("drain_count", 32'(bus.count), 32'd0);

      // Streaming across pointer wrap
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 16'(i), ~16'(i), 1'b1);
         clk_cyc();
         chk("stream_count", 32'(bus.count), 32'd1);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("stream_end_count", 32'(bus.count), 32'd0);

      // Flush overrides push and pop
      drive(1'b1, 16'h1111, 16'h2222, 1'b0);
      clk_cyc();
      drive(1'b1, 16'h3333, 16'h4444, 1'b0);
      clk_cyc();
      chk("pre_flush_count", 32'(bus.count), 32'd2);
      bus.flush = 1'b1;
      drive(1'b1, 16'h7777, 16'h8888, 1'b1);
      clk_cyc();
      bus.flush = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("flush_count", 32'(bus.count), 32'd0);
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      drive(1'b1, 16'hAAAA, 16'h5555, 1'b0);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("post_flush_a", 32'(bus.out_a), 32'hAAAA);
      chk("post_flush_b", 32'(bus.out_b), 32'h5555);
      chk("post_flush_count", 32'(bus.count), 32'd1);
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);

      // Async reset mid-cycle with three entries held
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'hC000 | 16'(i), 16'h0C00 | 16'(i), 1'b0);
         clk_cyc();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      chk("pre_arst_count", 32'(bus.count), 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_count", 32'(bus.count), 32'd0);
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_a", 32'(bus.out_a), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(1'b1, 16'h1234, 16'h4321, 1'b0);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b1);
      chk("post_rst_count", 32'(bus.count), 32'd1);
      clk_cyc();
      drive(1'b0, 16'h0, 16'h0, 1'b0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
